// File: rtl/car_sprite_vblank_sched.sv
// car_sprite_vblank_sched: queues car sprite updates (idx, x, y, ctrl) and
// drains them to the video-slot registers only during vertical blanking.
// Each entry produces three back-to-back writes and then one quiet cycle.
//
// state   | meaning
// IDLE    | bus quiet; start the head entry when in vblank and queue non-empty
// WR_X    | writing the x register of the latched sprite
// WR_Y    | writing the y register of the latched sprite
// WR_CTRL | writing the control nibble, then back to IDLE
module car_sprite_vblank_sched #(
  parameter int NUM_SPRITES = 20,
  parameter int FIFO_DEPTH  = 8,
  parameter int V_ACTIVE    = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [10:0]                   y,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [4:0]                    req_idx,
  input  logic [10:0]                   req_x,
  input  logic [10:0]                   req_y,
  input  logic [3:0]                    req_ctrl,
  input  logic                          err_clr,
  output logic                          cs,
  output logic                          write,
  output logic [13:0]                   addr,
  output logic [31:0]                   wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          err_idx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C   = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [10:0]   V_ACT_C   = V_ACTIVE[10:0];
  localparam logic [5:0]    NUM_C     = NUM_SPRITES[5:0];

  typedef struct packed {
    logic [4:0]  idx;
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  ctrl;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WR_X, WR_Y, WR_CTRL} state_t;

  state_t        state;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [10:0]   cur_y;
  logic [3:0]    cur_ctrl;
  logic [5:0]    off;
  logic [5:0]    head_off;
  logic          idx_ok, accept, push, pop, err_set, vblank;

  assign req_ready = (fifo_count < DEPTH_C);
  assign vblank    = (y >= V_ACT_C);
  assign idx_ok    = ({1'b0, req_idx} < NUM_C);
  assign accept    = req_valid & req_ready;
  assign push      = accept & idx_ok;
  assign err_set   = accept & ~idx_ok;
  assign pop       = (state == IDLE) & vblank & (fifo_count != '0);
  assign busy      = (state != IDLE) | (fifo_count != '0);

  assign head      = mem[rd_ptr];
  // Slot register offsets are 3*idx+1..3; 6-bit arithmetic wraps like the hardware map.
  assign head_off  = {1'b0, head.idx} * 6'd3 + 6'd1;

  // Queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{idx: req_idx, x: req_x, y: req_y, ctrl: req_ctrl};
  end

  // Queue pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky out-of-range flag; a new error outranks a clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_idx <= 1'b0;
    else if (err_set) err_idx <= 1'b1;
    else if (err_clr) err_idx <= 1'b0;
  end

  // Write sequencer with registered bus outputs; once started an entry always completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cs       <= 1'b0;
      write    <= 1'b0;
      addr     <= '0;
      wr_data  <= '0;
      cur_y    <= '0;
      cur_ctrl <= '0;
      off      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= WR_X;
            cur_y    <= head.y;
            cur_ctrl <= head.ctrl;
            off      <= head_off;
            cs       <= 1'b1;
            write    <= 1'b1;
            addr     <= {1'b1, 7'b0, head_off};
            wr_data  <= {21'b0, head.x};
          end
        end
        WR_X: begin
          state   <= WR_Y;
          off     <= off + 6'd1;
          addr    <= {1'b1, 7'b0, off + 6'd1};
          wr_data <= {21'b0, cur_y};
        end
        WR_Y: begin
          state   <= WR_CTRL;
          off     <= off + 6'd1;
          addr    <= {1'b1, 7'b0, off + 6'd1};
          wr_data <= {28'b0, cur_ctrl};
        end
        WR_CTRL: begin
          state   <= IDLE;
          cs      <= 1'b0;
          write   <= 1'b0;
          addr    <= '0;
          wr_data <= '0;
        end
        default: begin
          state   <= IDLE;
          cs      <= 1'b0;
          write   <= 1'b0;
          addr    <= '0;
          wr_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_sprite_vblank_sched.sv
// Bench for car_sprite_vblank_sched: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level queue model.
module tb_car_sprite_vblank_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] y = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_idx = '0;
  logic [10:0] req_x = '0;
  logic [10:0] req_y = '0;
  logic [3:0]  req_ctrl = '0;
  logic        err_clr = 1'b0;
  logic        cs, write, busy, err_idx;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  fifo_count;

  always #5 clk = ~clk;

  car_sprite_vblank_sched dut (
    .clk(clk), .reset(reset), .y(y),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .req_x(req_x), .req_y(req_y), .req_ctrl(req_ctrl), .err_clr(err_clr),
    .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
    .fifo_count(fifo_count), .busy(busy), .err_idx(err_idx)
  );

  typedef struct {logic [4:0] idx; logic [10:0] x; logic [10:0] yy; logic [3:0] ctrl;} ent_t;
  typedef struct {logic [13:0] addr; logic [31:0] data;} wr_t;

  ent_t mq[$];
  wr_t  pend[$];
  bit   m_act;
  wr_t  m_cur;
  bit   m_err;
  int   total = 0;
  int   bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic wr_t mk(logic [4:0] idx, int k, logic [31:0] d);
    wr_t w;
    logic [5:0] o;
    o = 6'(3 * int'(idx) + k);
    w.addr = {1'b1, 7'b0, o};
    w.data = d;
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_act = 0;
    m_cur = '{14'h0, 32'h0};
    m_err = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit rdy;
    rdy = (mq.size() < 8);
    if (!m_act && (y >= 11'd480) && mq.size() > 0) begin
      ent_t e;
      e = mq.pop_front();
      pend.push_back(mk(e.idx, 1, 32'(e.x)));
      pend.push_back(mk(e.idx, 2, 32'(e.yy)));
      pend.push_back(mk(e.idx, 3, 32'(e.ctrl)));
    end
    if (pend.size() > 0) begin
      m_cur = pend.pop_front();
      m_act = 1;
    end else begin
      m_cur = '{14'h0, 32'h0};
      m_act = 0;
    end
    if (req_valid && rdy && req_idx < 5'd20)
      mq.push_back('{req_idx, req_x, req_y, req_ctrl});
    if (req_valid && rdy && req_idx >= 5'd20) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic check_all();
    chk("cs", 32'(cs), 32'(m_act));
    chk("write", 32'(write), 32'(m_act));
    chk("addr", 32'(addr), 32'(m_cur.addr));
    chk("wr_data", wr_data, m_cur.data);
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("req_ready", 32'(req_ready), 32'(mq.size() < 8));
    chk("busy", 32'(busy), 32'(m_act || mq.size() != 0));
    chk("err_idx", 32'(err_idx), 32'(m_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(bit v, logic [4:0] i, logic [10:0] x, logic [10:0] yy, logic [3:0] c);
    req_valid = v;
    req_idx   = i;
    req_x     = x;
    req_y     = yy;
    req_ctrl  = c;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (m_act || mq.size() > 0); n++) step();
    step();
    chk("drain_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    chk("rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Single entry held until vblank, then three writes.
    y = 11'd100;
    drive(1, 5'd2, 11'd300, 11'd200, 4'd5);
    step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    chk("pre_vblank_cs", 32'(cs), 32'h0);
    y = 11'd480;
    step();
    chk("e1_addr_x", 32'(addr), 32'h2007);
    chk("e1_data_x", wr_data, 32'd300);
    step();
    chk("e1_addr_y", 32'(addr), 32'h2008);
    chk("e1_data_y", wr_data, 32'd200);
    step();
    chk("e1_addr_c", 32'(addr), 32'h2009);
    chk("e1_data_c", wr_data, 32'd5);
    step();
    chk("e1_busy_end", 32'(busy), 32'h0);

    // Fill the queue outside vblank, then pop with a request waiting.
    y = 11'd0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'(i * 2), 11'(100 + i), 11'(50 + i), 4'(i));
      step();
    end
    chk("full_ready", 32'(req_ready), 32'h0);
    drive(1, 5'd3, 11'd777, 11'd333, 4'd9);
    step();
    chk("full_count", 32'(fifo_count), 32'd8);
    y = 11'd500;
    step();
    chk("pop_count", 32'(fifo_count), 32'd7);
    chk("pop_ready", 32'(req_ready), 32'h1);
    step();
    drive(0, 0, 0, 0, 0);
    drain();

    // Out-of-range index.
    y = 11'd0;
    drive(1, 5'd25, 11'd1, 11'd1, 4'd1);
    step();
    drive(0, 0, 0, 0, 0);
    chk("err_set", 32'(err_idx), 32'h1);
    chk("err_count", 32'(fifo_count), 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", 32'(err_idx), 32'h0);
    drive(1, 5'd31, 11'd1, 11'd1, 4'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("err_wins", 32'(err_idx), 32'h1);

    // vblank ends mid-sequence; highest slot index offsets.
    drive(1, 5'd19, 11'd12, 11'd34, 4'd7);
    step();
    drive(1, 5'd4, 11'd56, 11'd78, 4'd2);
    step();
    drive(0, 0, 0, 0, 0);
    y = 11'd480;
    step();
    chk("i19_addr_x", 32'(addr), 32'h203A);
    y = 11'd0;
    step();
    chk("i19_addr_y", 32'(addr), 32'h203B);
    step();
    chk("i19_addr_c", 32'(addr), 32'h203C);
    for (int i = 0; i < 5; i++) step();
    chk("wait_next_vb", 32'(fifo_count), 32'd1);
    y = 11'd480;
    drain();

    // Random traffic.
    for (int c = 0; c < 1200; c++) begin
      if (c % 20 == 0)
        y = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(480, 524)) : 11'($urandom_range(0, 479));
      drive($urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19)),
            11'($urandom), 11'($urandom), 4'($urandom));
      err_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    err_clr = 1'b0;
    y = 11'd480;
    drain();

    // Reset in the middle of WR_Y with entries still queued.
    y = 11'd0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 5), 11'(i + 1), 11'(i + 2), 4'(i));
      step();
    end
    drive(0, 0, 0, 0, 0);
    y = 11'd480;
    step();
    step();
    chk("pre_rst_wry", 32'(addr), 32'h2011);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_cs", 32'(cs), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_cs", 32'(cs), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
